// File: rtl/pe_issue_sequencer_pkg.sv
// Shared definitions for the PE issue sequencer: ctrl word layout, halt opcode
// and the sequencer state encoding.
package pe_pkg;

    localparam int unsigned PE_CTRL_W = 13;

    // ctrl word layout: dst[12:10] op1[9:7] op2[6:4] opcode[3:0]
    localparam int unsigned DST_MSB = 12;
    localparam int unsigned DST_LSB = 10;
    localparam int unsigned OP1_MSB = 9;
    localparam int unsigned OP1_LSB = 7;
    localparam int unsigned OP2_MSB = 6;
    localparam int unsigned OP2_LSB = 4;
    localparam int unsigned OPC_MSB = 3;
    localparam int unsigned OPC_LSB = 0;

    localparam logic [3:0] PE_HALT_OPC = 4'hF;

    typedef logic [PE_CTRL_W-1:0] ctrl_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/pe_issue_sequencer_result_fifo.sv
// First-word-fall-through result FIFO with occupancy count; the head entry is
// visible on rdata whenever valid is high.
module pe_result_fifo
    import pe_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 36
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push,
    input  logic [WIDTH-1:0]        wdata,
    input  logic                    pop,
    output logic [WIDTH-1:0]        rdata,
    output logic                    valid,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (count != '0);
    // A pop frees the slot the same cycle, so a push at full is accepted then.
    assign do_push = push && ((count != FULL_CNT) || do_pop);
    assign valid   = (count != '0);
    assign rdata   = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/pe_issue_sequencer.sv
// Issues a stored ctrl program to a single PE one word per cycle under result
// credit, and collects the PE's returned results into an indexed FIFO.
module pe_issue_sequencer
    import pe_pkg::*;
#(
    parameter int unsigned PROG_DEPTH = 16,
    parameter int unsigned CTRL_W     = PE_CTRL_W,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned RES_DEPTH  = 8,
    parameter logic [3:0]  HALT_OPC   = PE_HALT_OPC
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          prog_we,
    input  logic [$clog2(PROG_DEPTH)-1:0] prog_addr,
    input  logic [CTRL_W-1:0]             prog_wdata,
    input  logic [$clog2(PROG_DEPTH):0]   prog_len,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    output logic [CTRL_W-1:0]             pe_ctrl,
    output logic                          pe_en,
    output logic                          pe_input_ready,
    input  logic                          pe_output_ready,
    input  logic [DATA_W-1:0]             pe_data_memory,
    output logic                          res_valid,
    output logic [DATA_W-1:0]             res_data,
    output logic [$clog2(PROG_DEPTH)-1:0] res_idx,
    input  logic                          res_ready,
    output logic                          err_unexpected
);

    localparam int unsigned AW = $clog2(PROG_DEPTH);
    localparam int unsigned CW = $clog2(RES_DEPTH) + 1;
    localparam logic [CW:0] RES_LIMIT = RES_DEPTH[CW:0];

    logic [CTRL_W-1:0] mem [PROG_DEPTH];

    state_t            state;
    state_t            state_nx;
    logic [AW:0]       pc;
    logic [AW:0]       pc_inc;
    logic [AW:0]       len;
    logic [CW-1:0]     outstanding;
    logic [CW-1:0]     fifo_count;
    logic [CW:0]       inflight;
    logic [AW-1:0]     ridx;
    logic [CTRL_W-1:0] cur_word;
    logic              cur_halt;
    logic              credit_ok;
    logic              issue;
    logic              ret_ok;
    logic              ret_bad;
    logic              run_start;
    logic [DATA_W+AW-1:0] fifo_rdata;

    assign cur_word  = mem[pc[AW-1:0]];
    assign cur_halt  = (cur_word[OPC_MSB:OPC_LSB] == HALT_OPC);
    assign pc_inc    = pc + 1'b1;
    // Results already queued and results still in the PE both hold a FIFO slot.
    assign inflight  = {1'b0, outstanding} + {1'b0, fifo_count};
    assign credit_ok = (inflight < RES_LIMIT);
    assign ret_ok    = pe_output_ready && (outstanding != '0);
    assign ret_bad   = pe_output_ready && (outstanding == '0);
    assign run_start = (state == IDLE) && start;

    assign pe_input_ready = pe_en;

    always_ff @(posedge clk) begin
        if (prog_we && (state == IDLE)) begin
            mem[prog_addr] <= prog_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = (prog_len == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                if (issue ? (pc_inc == len) : cur_halt) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                if (outstanding == '0) begin
                    state_nx = DONE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        issue = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
        case (state)
            ISSUE: begin
                busy  = 1'b1;
                issue = credit_ok && !cur_halt;
            end
            DRAIN:   busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc             <= '0;
            len            <= '0;
            outstanding    <= '0;
            ridx           <= '0;
            pe_ctrl        <= '0;
            pe_en          <= 1'b0;
            err_unexpected <= 1'b0;
        end else begin
            pe_en <= issue;
            if (issue) begin
                pe_ctrl <= cur_word;
                pc      <= pc_inc;
            end
            case ({issue, ret_ok})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: ;
            endcase
            if (ret_ok) begin
                ridx <= ridx + 1'b1;
            end
            if (ret_bad) begin
                err_unexpected <= 1'b1;
            end
            if (run_start) begin
                len  <= prog_len;
                pc   <= '0;
                ridx <= '0;
            end
        end
    end

    pe_result_fifo #(
        .DEPTH (RES_DEPTH),
        .WIDTH (DATA_W + AW)
    ) u_res_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (ret_ok),
        .wdata ({pe_data_memory, ridx}),
        .pop   (res_ready),
        .rdata (fifo_rdata),
        .valid (res_valid),
        .count (fifo_count)
    );

    assign {res_data, res_idx} = fifo_rdata;

endmodule
